// File: rtl/mips_data_mem_ctrl.sv
// mips_data_mem_ctrl: multicycle MIPS data-memory stage serving sw/lw over an internal word RAM
module mips_data_mem_ctrl #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h10010000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic                  wr_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [31:0]           offset;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  err;
  // addresses below BASE_ADDR wrap to a huge offset and fail the range check
  assign offset    = addr_q - BASE_ADDR;
  assign idx       = offset[ADDR_WIDTH+1:2];
  assign err       = (offset[1:0] != 2'b00) || (offset[31:ADDR_WIDTH+2] != '0);
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
  always_comb begin
    state_nx = state == IDLE ? (req_valid ? ACCESS : IDLE) : state == ACCESS ? RESP : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && req_valid) begin
      wr_q    <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && state == ACCESS && wr_q && !err) mem[idx] <= wdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= state == ACCESS;
      if (state == ACCESS) begin
        rsp_err   <= err;
        rsp_rdata <= (!wr_q && !err) ? mem[idx] : '0;
      end
    end
  end
endmodule

// File: tb/tb_mips_data_mem_ctrl.sv
// tb_mips_data_mem_ctrl: directed and randomized checks of the data-memory stage against a word-array model
module tb_mips_data_mem_ctrl;
  localparam logic [31:0] BASE = 32'h10010000;
  logic        clk = 0;
  logic        reset = 1;
  logic        req_valid = 0;
  logic        req_write = 0;
  logic [31:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  int          vectors = 0;
  int          errors = 0;
  logic [31:0] mem_m [int];

  mips_data_mem_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RAM is 256 words starting at BASE; model updates only on an accepted, completed request
  function automatic void model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                output logic e, output logic [31:0] r);
    logic [31:0] off;
    off = a - BASE;
    e = (off % 4 != 0) || (off >= 32'd1024);
    r = 0;
    if (!e) begin
      if (w) mem_m[int'(off / 4)] = d;
      else r = mem_m[int'(off / 4)];
    end
  endfunction

  // starts and ends at a negedge with the DUT idle
  task automatic xact(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic        e;
    logic [31:0] r;
    model(w, a, d, e, r);
    chk1({tag, ".ready"}, req_ready, 1'b1);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 0;
    chk1({tag, ".busy"}, busy, 1'b1);
    chk1({tag, ".early"}, rsp_valid, 1'b0);
    @(negedge clk);
    chk1({tag, ".valid"}, rsp_valid, 1'b1);
    chk1({tag, ".err"}, rsp_err, e);
    chk32({tag, ".rdata"}, rsp_rdata, r);
    @(negedge clk);
    chk1({tag, ".pulse"}, rsp_valid, 1'b0);
    chk32({tag, ".hold"}, rsp_rdata, r);
  endtask

  initial begin
    logic        e;
    logic [31:0] r, a, d;
    logic [31:0] exp_q [$];
    logic        w;
    // 1: reset
    repeat (2) @(negedge clk);
    reset = 0;
    chk1("rst.ready", req_ready, 1'b1);
    chk1("rst.busy", busy, 1'b0);
    chk1("rst.valid", rsp_valid, 1'b0);
    chk32("rst.rdata", rsp_rdata, 32'h0);
    chk1("rst.err", rsp_err, 1'b0);
    // known contents everywhere
    for (int i = 0; i < 256; i++) xact("fill", 1'b1, BASE + 32'(i * 4), $urandom);
    // 2..4: directed boundaries
    xact("sw0", 1'b1, BASE, 32'h2C);
    xact("lw0", 1'b0, BASE, 0);
    xact("swlast", 1'b1, 32'h100103FC, 32'hDEADBEEF);
    xact("lwlast", 1'b0, 32'h100103FC, 0);
    xact("lwpast", 1'b0, 32'h10010400, 0);
    xact("lwbelow", 1'b0, 32'h1000FFFC, 0);
    xact("lw0b", 1'b0, BASE, 0);
    xact("swmis", 1'b1, 32'h10010002, 32'h12345678);
    xact("lw0c", 1'b0, BASE, 0);
    chk32("ram0", mem_m[0], 32'h2C);
    // 5: req_valid held high, one accept per 3 cycles, responses in order
    req_valid = 1;
    for (int k = 0; k < 12; k++) begin
      chk1("hold.ready", req_ready, k % 3 == 0);
      chk1("hold.valid", rsp_valid, k % 3 == 2);
      if (k % 3 == 2) chk32("hold.rdata", rsp_rdata, exp_q.pop_front());
      if (k % 3 == 0) begin
        w = 1'(k / 3 % 2);
        a = (k / 3) % 2 ? BASE + 32'h40 : BASE + 32'h80;
        d = $urandom;
        model(w, a, d, e, r);
        exp_q.push_back(r);
        req_write = w; req_addr = a; req_wdata = d;
      end
      @(negedge clk);
    end
    req_valid = 0;
    chk1("hold.end", req_ready, 1'b1);
    // 6: reset during ACCESS suppresses the store and the response
    req_valid = 1; req_write = 1; req_addr = 32'h10010004; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 0;
    chk1("rsta.busy", busy, 1'b1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk1("rsta.valid", rsp_valid, 1'b0);
    chk1("rsta.idle", busy, 1'b0);
    @(negedge clk);
    chk1("rsta.valid2", rsp_valid, 1'b0);
    xact("rsta.lw", 1'b0, 32'h10010004, 0);
    // reset during RESP clears the pulse
    req_valid = 1; req_write = 0; req_addr = BASE + 8;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    chk1("rstr.valid", rsp_valid, 1'b1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk1("rstr.cleared", rsp_valid, 1'b0);
    chk1("rstr.busy", busy, 1'b0);
    chk32("rstr.rdata", rsp_rdata, 32'h0);
    // reset and req_valid together: request dropped
    reset = 1; req_valid = 1; req_write = 1; req_addr = BASE + 12; req_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    reset = 0; req_valid = 0;
    chk1("simul.busy", busy, 1'b0);
    @(negedge clk);
    chk1("simul.busy2", busy, 1'b0);
    chk1("simul.valid", rsp_valid, 1'b0);
    xact("simul.lw", 1'b0, BASE + 12, 0);
    // randomized mix including misaligned, past-end and below-base addresses
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: a = BASE + 32'($urandom_range(0, 1023));
        1: a = BASE + 32'($urandom_range(1024, 4096));
        2: a = BASE - 32'($urandom_range(1, 64));
        default: a = BASE + 32'($urandom_range(0, 255) * 4);
      endcase
      xact("rand", 1'($urandom_range(0, 1)), a, $urandom);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
